polar_encode_par: RTL and testbench
===================================

# polar_encode_par

Parametrised, W-bit-parallel polar transform core for the NR polar encoder datapath. It collects a frozen-bit-mapped u-vector of N = 2^n bits, with n selectable per frame, W bits per valid beat. It then computes x = u·F^{⊗n}, with F = [1 0; 1 1], in place, one butterfly stage per cycle, and streams x out W bits per cycle with start/end/valid framing. It replaces the serial mapping/encode pair between frame mapping and output buffering wherever more than one bit per clock is required.

## Interface
Parameters:
- W, default 4: bits per beat; power of 2, 1..64.
- NMAX_LOG2, default 10: largest supported log2(N); NMAX = 2^NMAX_LOG2 ≥ W.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  clock enable; when low, all state and outputs hold.
- dataIn  in  W  u-bits; bit j of beat k is u[k·W+j].
- ctrlIn_start  in  1  first beat of a frame.
- ctrlIn_end  in  1  last beat of a frame.
- ctrlIn_valid  in  1  beat qualifier.
- nIn  in  4  log2(N), sampled with the start beat.
- dataOut  out  W  x-bits; bit j of word k is x[k·W+j].
- ctrlOut_start  out  1  first output word.
- ctrlOut_end  out  1  last output word.
- ctrlOut_valid  out  1  output qualifier.
- nextFrame  out  1  high when a new start beat will be accepted.
- frameErr  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Storage: NMAX-bit register array U; beat counter of NMAX_LOG2 bits; stage counter of 4 bits; latched n.
- States: IDLE, LOAD, ENC, UNLOAD. nextFrame = (state == IDLE).
- IDLE:
  - Beat with valid & start: check nIn.
  - If log2(W) ≤ nIn ≤ NMAX_LOG2: latch n, write the beat to U[W-1:0], cnt = 1, go to LOAD.
  - Otherwise: pulse frameErr and stay in IDLE.
  - Valid beats without start are ignored.
  - Special case: if N == W, the start beat must also carry end. Then go directly to ENC. If end is absent, pulse frameErr and stay in IDLE.
- LOAD:
  - Each valid beat writes U[cnt·W +: W] and increments cnt. Gaps (valid low) are allowed.
  - Beat number N/W (cnt == N/W−1) must carry end. Go to ENC.
  - End on an earlier beat, or no end on beat N/W: pulse frameErr, drop the frame, return to IDLE.
  - Start during LOAD: pulse frameErr and restart the load with that beat as beat 0, after re-checking nIn.
- ENC:
  - n cycles. In stage s = 0..n−1, for every i < N with bit s of i clear: U[i] ^= U[i+2^s].
  - Bits at index ≥ N are don't-care.
  - After stage n−1, go to UNLOAD with cnt = 0.
- UNLOAD:
  - N/W contiguous cycles with registered outputs: dataOut = U[cnt·W +: W], valid = 1.
  - start = 1 on word 0; end = 1 on word N/W−1; both are 1 when N/W = 1.
  - Return to IDLE after the last word.
- Inputs presented in ENC/UNLOAD are ignored, with no error.
- dataOut = 0 whenever ctrlOut_valid = 0.

## Timing
- Reset values: dataOut = 0, ctrlOut_start/end/valid = 0, frameErr = 0, state = IDLE, so nextFrame = 1. U is not cleared.
- Reset wins over enb and over any in-flight frame. A reset mid-LOAD/ENC/UNLOAD forces all outputs to 0 on the next edge with no partial end.
- Latency, counted in enb-high cycles from the edge sampling the last input beat (cycle t):
  - ENC occupies t+1..t+n.
  - First output word is valid in cycle t+n+1.
  - Last output word is in t+n+N/W.
  - nextFrame rises in cycle t+n+N/W+1.
- Throughput: one frame per N/W (load) + n + N/W (unload) cycles, with no overlap.
- frameErr is registered: high exactly one cycle after the offending beat.
- With enb low, no counter advances; outputs, including an active valid, hold their values.

## Test plan
- W=4, n=3, u7=1 (words 0x0, 0x8, with start on the first word and end on the second): outputs are 0xF, 0xF. start on word 0, end on word 1, first valid 4 cycles after the last beat.
- W=4, n=3, u0=1 (words 0x1, 0x0): outputs are 0x1, 0x0. Then random u over 200 frames with n ∈ {2..10}, compared against a reference model x = u·F^{⊗n}, with random valid gaps and random enb deassertion.
- W=4, n=10, u1023=1: 256 all-0xF words; first valid arrives 11 cycles after the last beat; nextFrame is low for the whole frame.
- W=4, n=3, end on beat 1: frameErr pulses once, no output, nextFrame stays 1. nIn=1 at start: frameErr pulses, frame ignored.
- Start reasserted on beat 1 of an n=4 load: frameErr pulses once, then the new 4-beat frame encodes correctly.
- Reset asserted in UNLOAD word 2 of an n=5 frame: next cycle all outputs are 0 and nextFrame = 1; a following frame encodes correctly.

Source files
------------

// File: rtl/polar_encode_par.sv
// W-bit-parallel polar transform x = u * F^(kron n), F = [1 0; 1 1].
// Frames are loaded W bits per beat, butterflied in place one stage per cycle, then streamed out.
module polar_encode_par #(
    parameter int W         = 4,
    parameter int NMAX_LOG2 = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enb,
    input  logic [W-1:0] dataIn,
    input  logic         ctrlIn_start,
    input  logic         ctrlIn_end,
    input  logic         ctrlIn_valid,
    input  logic [3:0]   nIn,
    output logic [W-1:0] dataOut,
    output logic         ctrlOut_start,
    output logic         ctrlOut_end,
    output logic         ctrlOut_valid,
    output logic         nextFrame,
    output logic         frameErr
);
    localparam int NMAX = 1 << NMAX_LOG2;
    localparam int LW   = $clog2(W);
    localparam int CW   = NMAX_LOG2;

    typedef enum logic [1:0] {IDLE, LOAD, ENC, UNLOAD} state_t;

    state_t            state, state_n;
    logic [NMAX-1:0]   u, u_n, enc_u, part;
    logic [CW-1:0]     cnt, cnt_n;
    logic [3:0]        stage, stage_n, n_q, n_n, go_n;
    logic [W-1:0]      dout_n;
    logic              os_n, oe_n, ov_n, err_n, take, go;

    // Index of the last beat/word of a frame of size 2^n.
    function automatic logic [CW-1:0] beats_m1(input logic [3:0] n);
        int k;
        k = (1 << (int'(n) - LW)) - 1;
        return k[CW-1:0];
    endfunction

    function automatic logic n_ok(input logic [3:0] n);
        return (int'(n) >= LW) && (int'(n) <= NMAX_LOG2);
    endfunction

    // One butterfly stage: every index with bit s clear absorbs its partner at +2^s.
    always_comb begin
        enc_u = u;
        part  = '0;
        for (int s = 0; s < NMAX_LOG2; s++) begin
            if (stage == 4'(s)) begin
                part = u >> (1 << s);
                for (int i = 0; i < NMAX; i++)
                    if (((i >> s) & 1) == 0) enc_u[i] = u[i] ^ part[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stage_n = stage;
        n_n     = n_q;
        u_n     = u;
        dout_n  = '0;
        os_n    = 1'b0;
        oe_n    = 1'b0;
        ov_n    = 1'b0;
        err_n   = 1'b0;
        take    = 1'b0;
        go      = 1'b0;
        go_n    = n_q;
        case (state)
            IDLE: if (ctrlIn_valid && ctrlIn_start) take = 1'b1;
            LOAD: if (ctrlIn_valid) begin
                if (ctrlIn_start) begin
                    take  = 1'b1;
                    err_n = 1'b1;
                end else begin
                    u_n[cnt*W +: W] = dataIn;
                    if (cnt == beats_m1(n_q)) begin
                        if (ctrlIn_end) go = 1'b1;
                        else begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (ctrlIn_end) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ENC: begin
                u_n     = enc_u;
                stage_n = stage + 4'd1;
                // The final stage also registers word 0 so output starts right after ENC.
                if (stage == n_q - 4'd1) begin
                    state_n = UNLOAD;
                    dout_n  = enc_u[W-1:0];
                    os_n    = 1'b1;
                    ov_n    = 1'b1;
                    oe_n    = (beats_m1(n_q) == '0);
                    cnt_n   = 1;
                end
            end
            UNLOAD: begin
                if (ctrlOut_end) begin
                    state_n = IDLE;
                end else begin
                    dout_n = u[cnt*W +: W];
                    ov_n   = 1'b1;
                    oe_n   = (cnt == beats_m1(n_q));
                    cnt_n  = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A start beat must carry end exactly when the frame is a single beat.
        if (take) begin
            if (!n_ok(nIn) || (ctrlIn_end != (int'(nIn) == LW))) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else begin
                n_n        = nIn;
                u_n[W-1:0] = dataIn;
                cnt_n      = 1;
                if (ctrlIn_end) begin
                    go   = 1'b1;
                    go_n = nIn;
                end else begin
                    state_n = LOAD;
                end
            end
        end

        // n = 0 has no butterfly stages, so the single word goes straight out.
        if (go) begin
            if (go_n == 4'd0) begin
                state_n = UNLOAD;
                dout_n  = u_n[W-1:0];
                os_n    = 1'b1;
                oe_n    = 1'b1;
                ov_n    = 1'b1;
            end else begin
                state_n = ENC;
                stage_n = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            stage         <= '0;
            n_q           <= '0;
            dataOut       <= '0;
            ctrlOut_start <= 1'b0;
            ctrlOut_end   <= 1'b0;
            ctrlOut_valid <= 1'b0;
            frameErr      <= 1'b0;
        end else if (enb) begin
            state         <= state_n;
            cnt           <= cnt_n;
            stage         <= stage_n;
            n_q           <= n_n;
            dataOut       <= dout_n;
            ctrlOut_start <= os_n;
            ctrlOut_end   <= oe_n;
            ctrlOut_valid <= ov_n;
            frameErr      <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enb) u <= u_n;
    end

    assign nextFrame = (state == IDLE);
endmodule

// File: tb/tb_polar_encode_par.sv
// Randomised bench for polar_encode_par; the reference model computes x[j] as the
// XOR of u[i] over all i whose bit set contains j (row rule of F kron n).
module tb_polar_encode_par;
    localparam int W    = 4;
    localparam int NL   = 10;
    localparam int NMAX = 1 << NL;

    logic         clk = 1'b0;
    logic         reset, enb;
    logic [W-1:0] dataIn;
    logic         ctrlIn_start, ctrlIn_end, ctrlIn_valid;
    logic [3:0]   nIn;
    logic [W-1:0] dataOut;
    logic         ctrlOut_start, ctrlOut_end, ctrlOut_valid, nextFrame, frameErr;

    polar_encode_par #(.W(W), .NMAX_LOG2(NL)) dut (
        .clk(clk), .reset(reset), .enb(enb), .dataIn(dataIn),
        .ctrlIn_start(ctrlIn_start), .ctrlIn_end(ctrlIn_end), .ctrlIn_valid(ctrlIn_valid),
        .nIn(nIn), .dataOut(dataOut), .ctrlOut_start(ctrlOut_start),
        .ctrlOut_end(ctrlOut_end), .ctrlOut_valid(ctrlOut_valid),
        .nextFrame(nextFrame), .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
        logic         e;
    } ow_t;

    ow_t oq[$];
    int  total = 0;
    int  pass_cnt = 0;
    int  err_cnt = 0;
    bit  nf_hi_load;

    // Words and error pulses count once per enabled cycle.
    always @(negedge clk) begin
        if (!reset && enb) begin
            if (ctrlOut_valid) oq.push_back({dataOut, ctrlOut_start, ctrlOut_end});
            if (frameErr) err_cnt++;
        end
    end

    function automatic logic [NMAX-1:0] ref_x(input logic [NMAX-1:0] uv, input int n);
        logic [NMAX-1:0] x;
        int N;
        x = '0;
        N = 1 << n;
        for (int j = 0; j < N; j++)
            for (int i = j; i < N; i = (i + 1) | j) x[j] = x[j] ^ uv[i];
        return x;
    endfunction

    function automatic logic [NMAX-1:0] rand_u();
        logic [NMAX-1:0] v;
        for (int k = 0; k < NMAX / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // -1 when the captured words match the model frame, else the first bad index.
    function automatic int first_bad(input int n, input logic [NMAX-1:0] uv);
        logic [NMAX-1:0] xv;
        int nw;
        xv = ref_x(uv, n);
        nw = (1 << n) / W;
        if (oq.size() != nw) return nw;
        for (int k = 0; k < nw; k++)
            if (oq[k].d !== xv[k*W +: W] || oq[k].s !== (k == 0) || oq[k].e !== (k == nw - 1))
                return k;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrlIn_valid = 1'b0;
        ctrlIn_start = 1'b0;
        ctrlIn_end   = 1'b0;
        dataIn       = '0;
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic s, input logic e, input int n);
        enb = 1'b1;
        ctrlIn_valid = 1'b1;
        ctrlIn_start = s;
        ctrlIn_end = e;
        dataIn = d;
        nIn = 4'(n);
        step();
        idle_inputs();
    endtask

    task automatic send_frame(input int n, input logic [NMAX-1:0] uv, input bit rnd);
        int nb, k, guard;
        nb = (1 << n) / W;
        k = 0;
        guard = 0;
        nf_hi_load = 1'b0;
        while (k < nb && guard < 20000) begin
            enb          = rnd ? ($urandom_range(7) != 0) : 1'b1;
            ctrlIn_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
            dataIn       = uv[k*W +: W];
            ctrlIn_start = (k == 0);
            ctrlIn_end   = (k == nb - 1);
            nIn          = 4'(n);
            step();
            if (enb && ctrlIn_valid) begin
                k++;
                if (nextFrame) nf_hi_load = 1'b1;
            end
            guard++;
        end
        idle_inputs();
        enb = 1'b1;
    endtask

    // Garbage on the inputs while encoding/unloading must be ignored.
    task automatic wait_out(input int nw, input bit rnd);
        int c;
        c = 0;
        while (oq.size() < nw && c < 20000) begin
            if (rnd) begin
                enb          = ($urandom_range(7) != 0);
                ctrlIn_valid = 1'($urandom_range(1));
                ctrlIn_start = 1'($urandom_range(1));
                ctrlIn_end   = 1'($urandom_range(1));
                dataIn       = W'($urandom);
                nIn          = 4'($urandom);
            end
            step();
            c++;
        end
        enb = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enb = 1'b0;
        nIn = 4'd0;
        idle_inputs();
        step();
        step();
        total++; if (dataOut !== '0) $display("FAIL reset_data got %h need 0", dataOut); else pass_cnt++;
        total++; if ({ctrlOut_start, ctrlOut_end, ctrlOut_valid} !== 3'b000)
            $display("FAIL reset_ctrl got %b need 000", {ctrlOut_start, ctrlOut_end, ctrlOut_valid}); else pass_cnt++;
        total++; if (frameErr !== 1'b0) $display("FAIL reset_err got %b need 0", frameErr); else pass_cnt++;
        total++; if (nextFrame !== 1'b1) $display("FAIL reset_nextFrame got %b need 1", nextFrame); else pass_cnt++;
        reset = 1'b0;
        enb = 1'b1;
        step();
    endtask

    task automatic test_directed();
        int n_t[3]  = '{3, 3, 10};
        int idx_t[3] = '{7, 0, 1023};
        logic [W-1:0] w0_t[3] = '{4'hF, 4'h1, 4'hF};
        logic [NMAX-1:0] uv;
        int n, nw, first_v, bad;
        bit nf_bad;
        for (int t = 0; t < 3; t++) begin
            n = n_t[t];
            nw = (1 << n) / W;
            uv = '0;
            uv[idx_t[t]] = 1'b1;
            oq.delete();
            send_frame(n, uv, 1'b0);
            first_v = -1;
            nf_bad = 1'b0;
            for (int c = 1; c <= n + nw; c++) begin
                if (nextFrame) nf_bad = 1'b1;
                if (ctrlOut_valid && first_v < 0) first_v = c;
                step();
            end
            total++; if (first_v != n + 1)
                $display("FAIL latency_%0d got %0d need %0d", t, first_v, n + 1); else pass_cnt++;
            total++; if (nf_bad || nf_hi_load)
                $display("FAIL nextFrame_busy_%0d got high need low", t); else pass_cnt++;
            total++; if (nextFrame !== 1'b1 || ctrlOut_valid !== 1'b0)
                $display("FAIL frame_done_%0d got nf=%b v=%b need nf=1 v=0", t, nextFrame, ctrlOut_valid); else pass_cnt++;
            bad = first_bad(n, uv);
            total++; if (bad != -1)
                $display("FAIL frame_dir_%0d first_bad=%0d words got %0d need %0d", t, bad, oq.size(), nw); else pass_cnt++;
            total++; if (oq.size() == 0 || oq[0].d !== w0_t[t])
                $display("FAIL word0_%0d got %h need %h", t, (oq.size() > 0) ? oq[0].d : 4'h0, w0_t[t]); else pass_cnt++;
        end
    endtask

    task automatic test_early_end();
        int e0;
        e0 = err_cnt;
        oq.delete();
        drive_beat(4'h8, 1'b1, 1'b1, 3);
        total++; if (frameErr !== 1'b1) $display("FAIL early_end_pulse got %b need 1", frameErr); else pass_cnt++;
        total++; if (nextFrame !== 1'b1) $display("FAIL early_end_nf got %b need 1", nextFrame); else pass_cnt++;
        drive_beat(4'h3, 1'b0, 1'b1, 3);
        total++; if (frameErr !== 1'b0) $display("FAIL early_end_once got %b need 0", frameErr); else pass_cnt++;
        repeat (10) step();
        total++; if (err_cnt - e0 != 1 || oq.size() != 0)
            $display("FAIL early_end_quiet errs got %0d need 1 words got %0d need 0", err_cnt - e0, oq.size()); else pass_cnt++;
    endtask

    task automatic test_bad_n();
        int e0;
        e0 = err_cnt;
        oq.delete();
        drive_beat(4'h5, 1'b1, 1'b1, 1);
        total++; if (frameErr !== 1'b1 || nextFrame !== 1'b1)
            $display("FAIL bad_n got err=%b nf=%b need err=1 nf=1", frameErr, nextFrame); else pass_cnt++;
        repeat (8) step();
        total++; if (err_cnt - e0 != 1 || oq.size() != 0)
            $display("FAIL bad_n_quiet errs got %0d need 1 words got %0d need 0", err_cnt - e0, oq.size()); else pass_cnt++;
    endtask

    task automatic test_restart();
        logic [NMAX-1:0] ua, ub;
        int e0, bad;
        ua = rand_u();
        ub = rand_u();
        e0 = err_cnt;
        oq.delete();
        drive_beat(ua[3:0], 1'b1, 1'b0, 4);
        drive_beat(ub[3:0], 1'b1, 1'b0, 4);
        total++; if (frameErr !== 1'b1) $display("FAIL restart_pulse got %b need 1", frameErr); else pass_cnt++;
        for (int k = 1; k < 4; k++) drive_beat(ub[k*W +: W], 1'b0, (k == 3), 4);
        wait_out(4, 1'b0);
        bad = first_bad(4, ub);
        total++; if (bad != -1) $display("FAIL restart_frame first_bad=%0d words got %0d need 4", bad, oq.size()); else pass_cnt++;
        total++; if (err_cnt - e0 != 1) $display("FAIL restart_errs got %0d need 1", err_cnt - e0); else pass_cnt++;
    endtask

    task automatic test_reset_unload();
        logic [NMAX-1:0] uv;
        int c, bad;
        uv = rand_u();
        oq.delete();
        send_frame(5, uv, 1'b0);
        c = 0;
        while (!ctrlOut_valid && c < 50) begin step(); c++; end
        step();
        step();
        total++; if (oq.size() != 2 || ctrlOut_valid !== 1'b1)
            $display("FAIL reset_pre words got %0d need 2 v=%b", oq.size(), ctrlOut_valid); else pass_cnt++;
        reset = 1'b1;
        step();
        total++; if ({dataOut, ctrlOut_start, ctrlOut_end, ctrlOut_valid, frameErr} !== '0 || nextFrame !== 1'b1)
            $display("FAIL reset_unload got d=%h s=%b e=%b v=%b err=%b nf=%b need all 0 nf=1",
                     dataOut, ctrlOut_start, ctrlOut_end, ctrlOut_valid, frameErr, nextFrame); else pass_cnt++;
        reset = 1'b0;
        oq.delete();
        step();
        uv = rand_u();
        send_frame(5, uv, 1'b0);
        wait_out(8, 1'b0);
        bad = first_bad(5, uv);
        total++; if (bad != -1) $display("FAIL after_reset_frame first_bad=%0d words got %0d need 8", bad, oq.size()); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [NMAX-1:0] uv;
        int n, bad, e0;
        e0 = err_cnt;
        for (int f = 0; f < 200; f++) begin
            n = $urandom_range(10, 2);
            uv = rand_u();
            oq.delete();
            send_frame(n, uv, 1'b1);
            wait_out((1 << n) / W, 1'b1);
            bad = first_bad(n, uv);
            total++; if (bad != -1)
                $display("FAIL rand_frame_%0d n=%0d first_bad=%0d words got %0d need %0d",
                         f, n, bad, oq.size(), (1 << n) / W); else pass_cnt++;
        end
        total++; if (err_cnt != e0) $display("FAIL rand_errs got %0d need 0", err_cnt - e0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_early_end();
        test_bad_n();
        test_restart();
        test_reset_unload();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
